// File: rtl/palette_lut_banked.sv
// palette_lut_banked: writable multi-bank colour palette for the pixel path.
// A pixel index goes in every clock. Registered RGB comes out two cycles later,
// scaled by a global brightness. Brightness fades toward a target one step per
// FADE_DIV frames. Bank swaps only take effect at frame start.
//
// Ports:
//   Clk, Reset_n          pixel clock, async active-low reset
//   busy                  high during the post-reset clear sweep
//   wr_en/bank/addr/data  palette entry write (ignored while busy)
//   swap_req/swap_bank    request a display bank for the next frame
//   active_bank           bank currently displayed
//   frame_start           one-cycle pulse at the start of each frame
//   fade_start/target     load a new brightness target
//   brightness, fade_busy current brightness, brightness != target
//   pix_valid_in, index   pixel index and its qualifier
//   pix_valid, red, green, blue, is_key   scaled colour output, latency 2
module palette_lut_banked #(
  parameter int IDX_W    = 4,
  parameter int CH_W     = 4,
  parameter int BANKS    = 2,
  parameter int FADE_DIV = 1,
  localparam int BW      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic              busy,
  input  logic              wr_en,
  input  logic [BW-1:0]     wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic [BW-1:0]     swap_bank,
  output logic [BW-1:0]     active_bank,
  input  logic              frame_start,
  input  logic              fade_start,
  input  logic [CH_W-1:0]   fade_target,
  output logic [CH_W-1:0]   brightness,
  output logic              fade_busy,
  input  logic              pix_valid_in,
  input  logic [IDX_W-1:0]  index,
  output logic              pix_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              is_key
);
  localparam int STAGES  = 2;
  localparam int DEPTH   = 1 << IDX_W;
  localparam int ENTRIES = BANKS * DEPTH;
  localparam int AW      = BW + IDX_W;
  localparam int EW      = 3 * CH_W;
  localparam int DW      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [BW:0]   NBANK    = (BW+1)'(BANKS);
  localparam logic [AW-1:0] LAST     = AW'(ENTRIES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);

  // ---------------- clear FSM ----------------
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_addr == LAST) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  // ---------------- palette storage ----------------
  // Flat array addressed {bank, entry}; the sweep walks it linearly.
  logic [EW-1:0] mem [ENTRIES];
  logic          wr_ok;

  assign wr_ok = (state == RUN) && wr_en && ({1'b0, wr_bank} < NBANK);

  always_ff @(posedge Clk) begin
    if (state == CLEAR)
      mem[clr_addr] <= '0;
    else if (wr_ok)
      mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // ---------------- swap control ----------------
  logic [BW-1:0] pend_bank;
  logic          pend_vld;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank <= '0;
      pend_bank   <= '0;
      pend_vld    <= 1'b0;
    end else begin
      if (frame_start && pend_vld) begin
        active_bank <= pend_bank;
        pend_vld    <= 1'b0;
      end
      // A request arriving with frame_start waits for the next frame.
      if (swap_req && ({1'b0, swap_bank} < NBANK)) begin
        pend_bank <= swap_bank;
        pend_vld  <= 1'b1;
      end
    end
  end

  // ---------------- fade control ----------------
  logic [CH_W-1:0] target;
  logic [DW-1:0]   div;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brightness <= '1;
      target     <= '1;
      div        <= '0;
    end else if (fade_start) begin
      // New target wins over a coincident frame step.
      target <= fade_target;
      div    <= '0;
    end else if (frame_start) begin
      if (div == DIV_LAST) begin
        div <= '0;
        if (brightness < target)      brightness <= brightness + 1'b1;
        else if (brightness > target) brightness <= brightness - 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign fade_busy = (brightness != target);

  // ---------------- lookup pipeline ----------------
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [CH_W-1:0] b);
    logic [2*CH_W:0] p;
    p = {{(CH_W+1){1'b0}}, c} * ({{CH_W{1'b0}}, b} + (2*CH_W+1)'(1));
    return CH_W'(p >> CH_W);
  endfunction

  logic              vld_in;
  logic [STAGES:1]   vld_pipe;
  logic [EW-1:0]     ent_s1;
  logic              key_s1;

  // Inputs are dropped during the sweep; the pipe then drains on its own.
  assign vld_in = pix_valid_in && (state == RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
      ent_s1   <= '0;
      key_s1   <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      is_key   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
      ent_s1   <= mem[{active_bank, index}];
      key_s1   <= (index == '0);
      if (vld_pipe[1]) begin
        red    <= scale(ent_s1[3*CH_W-1:2*CH_W], brightness);
        green  <= scale(ent_s1[2*CH_W-1:CH_W],   brightness);
        blue   <= scale(ent_s1[CH_W-1:0],        brightness);
        is_key <= key_s1;
      end else begin
        red    <= '0;
        green  <= '0;
        blue   <= '0;
        is_key <= 1'b0;
      end
    end
  end

  assign pix_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_palette_lut_banked.sv
// Self-checking bench for palette_lut_banked (IDX_W=4, CH_W=4, BANKS=2,
// FADE_DIV=1). Pixel expectations are queued with their due cycle when the
// index is driven and compared by a monitor every negedge.
module tb_palette_lut_banked;
  localparam int BW = 1;

  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        busy, wr_en, swap_req, frame_start, fade_start, fade_busy;
  logic        pix_valid_in, pix_valid, is_key;
  logic [BW-1:0] wr_bank, swap_bank, active_bank;
  logic [3:0]  wr_addr, index, fade_target, brightness, red, green, blue;
  logic [11:0] wr_data;

  palette_lut_banked #(.IDX_W(4), .CH_W(4), .BANKS(2), .FADE_DIV(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .busy(busy),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_bank(swap_bank), .active_bank(active_bank),
    .frame_start(frame_start), .fade_start(fade_start), .fade_target(fade_target),
    .brightness(brightness), .fade_busy(fade_busy),
    .pix_valid_in(pix_valid_in), .index(index), .pix_valid(pix_valid),
    .red(red), .green(green), .blue(blue), .is_key(is_key));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int due; logic [12:0] val; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;

  // reference model state
  logic [11:0] mdl [2][16];
  logic        mdl_act = 1'b0, mdl_pend = 1'b0, mdl_pend_v = 1'b0;
  logic [3:0]  mdl_br = 4'hF, mdl_tgt = 4'hF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sc(input logic [3:0] c, input logic [3:0] b);
    return 4'((int'(c) * (int'(b) + 1)) / 16);
  endfunction

  // Monitor: output must match the queue head exactly on its due cycle,
  // and be all-zero otherwise.
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      chk("pix_late", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      chk("pix_valid", pix_valid, 1);
      chk("pix_data", {is_key, red, green, blue}, mon_e.val);
    end else begin
      chk("pix_idle", {pix_valid, is_key, red, green, blue}, 0);
    end
  end

  task automatic pxe(input logic [3:0] idx, input logic [12:0] val);
    exp_t e;
    @(negedge Clk);
    pix_valid_in = 1'b1;
    index        = idx;
    e.due = cyc + 2;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic px(input logic [3:0] idx);
    logic [11:0] ent;
    ent = mdl[mdl_act][idx];
    pxe(idx, {idx == 4'd0, sc(ent[11:8], mdl_br), sc(ent[7:4], mdl_br), sc(ent[3:0], mdl_br)});
  endtask

  task automatic drain();
    int k;
    @(negedge Clk);
    pix_valid_in = 1'b0;
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic wr(input logic b, input logic [3:0] a, input logic [11:0] d);
    @(negedge Clk);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    @(negedge Clk);
    wr_en = 1'b0;
    mdl[b][a] = d;
  endtask

  task automatic pulse(input logic fs, input logic sw, input logic sb,
                       input logic fd, input logic [3:0] ft);
    @(negedge Clk);
    frame_start = fs; swap_req = sw; swap_bank = sb; fade_start = fd; fade_target = ft;
    @(negedge Clk);
    frame_start = 1'b0; swap_req = 1'b0; fade_start = 1'b0;
    if (fs && mdl_pend_v) begin mdl_act = mdl_pend; mdl_pend_v = 1'b0; end
    if (sw) begin mdl_pend = sb; mdl_pend_v = 1'b1; end
    if (fd) mdl_tgt = ft;
    else if (fs && mdl_br != mdl_tgt) mdl_br = (mdl_br < mdl_tgt) ? mdl_br + 4'd1 : mdl_br - 4'd1;
    chk("active_bank", active_bank, mdl_act);
    chk("brightness", brightness, mdl_br);
    chk("fade_busy", fade_busy, mdl_br != mdl_tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) mdl[b][a] = '0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
    swap_req = 0; swap_bank = 0; frame_start = 0; fade_start = 0; fade_target = 0;
    pix_valid_in = 0; index = 0;

    // reset values
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 1);
    chk("rst_active", active_bank, 0);
    chk("rst_bright", brightness, 4'hF);
    chk("rst_fade_busy", fade_busy, 0);

    // partial sweep, then reset mid-sweep: full sweep must rerun
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk("busy_mid", busy, 1);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("busy_rst2", busy, 1);
    Reset_n = 1'b1;
    // write and pixel requests during the sweep must be ignored
    wr_en = 1'b1; wr_bank = 0; wr_addr = 4'd7; wr_data = 12'hFFF;
    pix_valid_in = 1'b1; index = 4'd1;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge Clk);
      cnt++;
    end
    wr_en = 1'b0; pix_valid_in = 1'b0;
    chk("clear_cycles", cnt, 32);

    // cleared contents, key flag
    px(4'd7); px(4'd0); px(4'd15);
    drain();

    // basic write / lookup
    wr(0, 4'd5, 12'hA09);
    pxe(4'd5, {1'b0, 4'hA, 4'h0, 4'h9});
    pxe(4'd0, {1'b1, 12'h000});
    drain();

    // back-to-back, no bubbles
    wr(0, 4'd1, 12'h123); wr(0, 4'd2, 12'h456); wr(0, 4'd3, 12'h333);
    px(4'd1); px(4'd2); px(4'd3);
    drain();

    // deferred swap
    wr(1, 4'd3, 12'hFFF);
    pulse(0, 1, 1, 0, 4'h0);
    px(4'd3);
    drain();
    pulse(1, 0, 0, 0, 4'h0);
    pxe(4'd3, {1'b0, 12'hFFF});
    px(4'd4);
    drain();
    // swap_req with frame_start: only the next frame_start switches
    pulse(1, 1, 0, 0, 4'h0);
    px(4'd3);
    drain();
    pulse(1, 0, 0, 0, 4'h0);
    pxe(4'd3, {1'b0, 12'h333});
    drain();

    // fade 15 -> 0, one step per frame
    wr(0, 4'd9, 12'hDDD);
    pulse(0, 0, 0, 1, 4'h0);
    for (int i = 0; i < 15; i++) begin
      pulse(1, 0, 0, 0, 4'h0);
      if (i == 0) begin
        pxe(4'd9, {1'b0, 12'hCCC});
        drain();
      end
    end
    chk("bright_zero", brightness, 4'h0);
    chk("fade_done", fade_busy, 0);
    pxe(4'd9, {1'b0, 12'h000});
    drain();
    // fade_start with frame_start: no step that cycle
    pulse(1, 0, 0, 1, 4'hF);
    pulse(1, 0, 0, 0, 4'h0);
    px(4'd9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/palette_lut_banked.md
Name: palette_lut_banked

Overview:
- Parametrised, writable, multi-bank colour palette for the VGA pixel path; replaces fixed 16-entry constant palettes.
- Sprite/background logic supplies a pixel index per clock. The block returns registered RGB scaled by a global brightness.
- Brightness can fade toward a target, one step per frame (or per FADE_DIV frames).
- Bank swaps are deferred to frame start so the displayed palette never tears mid-frame.

Parameters:
- IDX_W, 4, index width; each bank holds 2**IDX_W entries.
- CH_W, 4, bits per colour channel; entry width is 3*CH_W, packed {r,g,b}.
- BANKS, 2, number of palette banks (>=1); bank-select width BW = max(1, clog2(BANKS)).
- FADE_DIV, 1, frames per brightness step (>=1).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- busy  out  1  high while the post-reset clear sweep runs.
- wr_en  in  1  write strobe; ignored while busy.
- wr_bank  in  BW  bank to write.
- wr_addr  in  IDX_W  entry to write.
- wr_data  in  3*CH_W  {r,g,b} to write.
- swap_req  in  1  one-cycle request to display swap_bank from the next frame.
- swap_bank  in  BW  requested display bank.
- active_bank  out  BW  bank currently displayed.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- fade_start  in  1  loads the fade target.
- fade_target  in  CH_W  brightness target.
- brightness  out  CH_W  current brightness.
- fade_busy  out  1  high while brightness != target.
- pix_valid_in  in  1  index qualifier.
- index  in  IDX_W  pixel palette index.
- pix_valid  out  1  output qualifier.
- red, green, blue  out  CH_W each  scaled colour.
- is_key  out  1  high when the source index was 0 (transparency key), aligned with the colour outputs.

Behaviour:
- Reset (async assert, release synchronous to Clk):
  - active_bank=0, pending request cleared, brightness=all-ones, fade target=all-ones, fade_busy=0.
  - Pipeline outputs pix_valid, red, green, blue and is_key are all 0.
  - busy=1.
- Clear FSM, states CLEAR and RUN:
  - CLEAR writes 0 to every entry of every bank, one entry per cycle. It takes BANKS*2**IDX_W cycles, then moves to RUN with busy=0.
  - wr_en is ignored in CLEAR.
  - pix_valid is forced to 0 in CLEAR and for the 2 cycles after it, until the pipeline flushes.
  - Reset asserted mid-sweep restarts CLEAR from entry 0.
- Write path:
  - In RUN, wr_en writes entry wr_addr of bank wr_bank at the clock edge.
  - Writes to the active bank are allowed.
  - Read-during-write to the same entry returns the old value.
- Lookup pipeline, latency 2 cycles:
  - Stage 1 registers the raw entry from active_bank, plus the valid bit and key bit.
  - Stage 2 registers the scaled channels, c_out = (c*(brightness+1)) >> CH_W, computed with an intermediate width of 2*CH_W+1.
  - brightness=max gives c_out=c; brightness=0 gives c_out=0 for every c.
  - When pix_valid=0, red, green, blue and is_key hold 0.
  - Brightness is sampled in stage 2. A step lands only on a frame_start cycle, so a visible frame never mixes brightness levels.
- Swap:
  - swap_req registers swap_bank as pending; a later swap_req overwrites it.
  - On frame_start with a request pending, active_bank takes the pending bank and pending is cleared.
  - swap_req in the same cycle as frame_start takes effect at the following frame_start.
  - swap_bank >= BANKS is ignored.
- Fade:
  - fade_start loads the target and resets the frame divider.
  - A frame divider counts frame_start pulses. At FADE_DIV pulses, brightness steps ±1 toward the target and the divider reloads.
  - fade_busy = (brightness != target).
  - fade_start coincident with frame_start: the new target is used and no step is taken that cycle.
- Simultaneous frame_start, swap and step all apply on the same edge.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles (IDX_W=4, BANKS=2); pix_valid=0 throughout. Then any index reads back r=g=b=0.
- Write bank0 entry5=12'hA09 and drive index=5 with valid -> 2 cycles later red=A, green=0, blue=9; is_key=0. index=0 -> is_key=1.
- Write bank1 entry3=12'hFFF, pulse swap_req bank1 mid-frame -> index 3 still shows bank0 until the next frame_start, then shows F,F,F. Also cover swap_req on the same cycle as frame_start -> no swap until the second frame_start.
- fade_start target 0 from 15, FADE_DIV=1, 15 frame_starts -> brightness decrements once per frame to 0. A channel value of 0xD reads 0xC at brightness 14 and 0 at brightness 0. fade_busy falls on reaching 0.
- wr_en asserted during CLEAR -> entry remains 0. Reset asserted mid-CLEAR -> busy stays high and a full 32-cycle sweep reruns.
- Back-to-back indices 1,2,3 each cycle -> outputs appear in order on consecutive cycles with no bubbles.
